delay_sum_beamformer: RTL and testbench

// Parametrised delay-and-sum beamformer for the PDM-to-PCM mic array. Holds a per-mic ring buffer of
// PCM history and taps each buffer at a per-mic steering delay. The taps are summed, scaled and emitted
// as one beam sample. Steering delays are reloaded at runtime from an external delay table (ROM/RAM)
// by a load FSM, then committed atomically so no output sample mixes old and new delays.

---
 rtl/delay_sum_beamformer.sv | 171 +++++++++++++++++
 tb/tb_delay_sum_beamformer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per-mic PCM ring buffers tapped at runtime-loadable steering delays.
// Define OUT_SAT_EN to saturate the beam output; otherwise the scaled sum wraps to BIT_WIDTH bits.
module delay_sum_beamformer #(
   parameter int BIT_WIDTH = 8,
   parameter int NUM_MICS  = 25,
   parameter int MAX_DELAY = 32,
   parameter int SUM_SHIFT = 4,
   parameter int DELAY_W   = $clog2(MAX_DELAY)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pcm_valid_in,
   input  logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_in,
   input  logic                          steer_req,
   output logic                          steer_busy,
   output logic [$clog2(NUM_MICS)-1:0]   delay_addr,
   input  logic [7:0]                    delay_rd_data,
   output logic                          delay_clamped,
   output logic                          out_valid,
   output logic signed [BIT_WIDTH-1:0]   delay_sum_data_out,
   output logic                          sat_flag
);
   localparam int ADDR_W = $clog2(NUM_MICS);
   localparam int CNT_W  = $clog2(NUM_MICS + 1);
   localparam int SUM_W  = BIT_WIDTH + $clog2(NUM_MICS) + 1;

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t                      state;
   logic [CNT_W-1:0]            cnt;
   logic [DELAY_W-1:0]          wr_ptr;
   logic [DELAY_W-1:0]          active_dly [NUM_MICS];
   logic [DELAY_W-1:0]          shadow_dly [NUM_MICS];
   logic signed [BIT_WIDTH-1:0] ring       [NUM_MICS][MAX_DELAY];
   logic signed [BIT_WIDTH-1:0] tap        [NUM_MICS];
   logic signed [BIT_WIDTH-1:0] tap_p1     [NUM_MICS];
   logic                        vld_p1;
   logic signed [SUM_W-1:0]     sum_p1;

   function automatic logic over_range(input logic [7:0] d);
      return int'(d) >= MAX_DELAY;
   endfunction

   function automatic logic [DELAY_W-1:0] clamp_delay(input logic [7:0] d);
      if (over_range(d)) return DELAY_W'(MAX_DELAY - 1);
      return d[DELAY_W-1:0];
   endfunction

   function automatic logic signed [SUM_W-1:0] sext(input logic signed [BIT_WIDTH-1:0] v);
      return {{(SUM_W-BIT_WIDTH){v[BIT_WIDTH-1]}}, v};
   endfunction

`ifdef OUT_SAT_EN
   localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((2 ** (BIT_WIDTH-1)) - 1);
   localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(2 ** (BIT_WIDTH-1)));

   function automatic logic is_clipped(input logic signed [SUM_W-1:0] v);
      return (v > OUT_MAX) || (v < OUT_MIN);
   endfunction

   function automatic logic signed [BIT_WIDTH-1:0] fit_out(input logic signed [SUM_W-1:0] v);
      if (v > OUT_MAX) return OUT_MAX[BIT_WIDTH-1:0];
      if (v < OUT_MIN) return OUT_MIN[BIT_WIDTH-1:0];
      return v[BIT_WIDTH-1:0];
   endfunction
`else
   function automatic logic signed [BIT_WIDTH-1:0] fit_out(input logic signed [SUM_W-1:0] v);
      return v[BIT_WIDTH-1:0];
   endfunction
`endif

   // Delay 0 bypasses the ring so the sample arriving this cycle is tapped directly.
   always_comb begin
      for (int m = 0; m < NUM_MICS; m++) begin
         tap[m] = pcm_data_in[m*BIT_WIDTH +: BIT_WIDTH];
         if (active_dly[m] != '0) tap[m] = ring[m][wr_ptr - active_dly[m]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         for (int m = 0; m < NUM_MICS; m++)
            for (int d = 0; d < MAX_DELAY; d++)
               ring[m][d] <= '0;
      end else if (pcm_valid_in) begin
         for (int m = 0; m < NUM_MICS; m++)
            ring[m][wr_ptr] <= pcm_data_in[m*BIT_WIDTH +: BIT_WIDTH];
         wr_ptr <= wr_ptr + DELAY_W'(1);
      end
   end

   // ---- stage 1: register taps ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= pcm_valid_in;
   end

   always_ff @(posedge clk) begin
      if (pcm_valid_in) tap_p1 <= tap;
   end

   // ---- stage 2: sum, scale, fit to output width ----
   always_comb begin
      sum_p1 = '0;
      for (int m = 0; m < NUM_MICS; m++) sum_p1 = sum_p1 + sext(tap_p1[m]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid          <= 1'b0;
         delay_sum_data_out <= '0;
         sat_flag           <= 1'b0;
      end else begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            delay_sum_data_out <= fit_out(sum_p1 >>> SUM_SHIFT);
`ifdef OUT_SAT_EN
            sat_flag <= is_clipped(sum_p1 >>> SUM_SHIFT);
`else
            sat_flag <= 1'b0;
`endif
         end
      end
   end

   // Table reads lag the address by one cycle, so LOAD runs one cycle past the last address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         delay_addr    <= '0;
         steer_busy    <= 1'b0;
         delay_clamped <= 1'b0;
         for (int m = 0; m < NUM_MICS; m++) begin
            shadow_dly[m] <= '0;
            active_dly[m] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (steer_req) begin
                  state      <= LOAD;
                  cnt        <= '0;
                  delay_addr <= '0;
                  steer_busy <= 1'b1;
               end
            end
            LOAD: begin
               for (int m = 0; m < NUM_MICS; m++)
                  if (cnt == CNT_W'(m + 1)) shadow_dly[m] <= clamp_delay(delay_rd_data);
               if (cnt != '0 && over_range(delay_rd_data)) delay_clamped <= 1'b1;
               if (cnt == CNT_W'(NUM_MICS)) begin
                  state      <= COMMIT;
                  delay_addr <= '0;
               end else begin
                  cnt        <= cnt + CNT_W'(1);
                  delay_addr <= (cnt < CNT_W'(NUM_MICS - 1)) ? ADDR_W'(cnt + CNT_W'(1)) : '0;
               end
            end
            COMMIT: begin
               active_dly <= shadow_dly;
               state      <= IDLE;
               steer_busy <= 1'b0;
               cnt        <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Randomized bench for delay_sum_beamformer against a sample-history reference model.
`timescale 1ns/1ps
module tb_delay_sum_beamformer;
   localparam int BW = 8;
   localparam int NM = 25;
   localparam int MD = 32;
   localparam int SS = 4;
   localparam int OMAX = (1 << (BW-1)) - 1;
   localparam int OMIN = -(1 << (BW-1));

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pcm_valid_in = 1'b0;
   logic [NM*BW-1:0]  pcm_data_in = '0;
   logic              steer_req = 1'b0;
   logic              steer_busy;
   logic [4:0]        delay_addr;
   logic [7:0]        delay_rd_data = '0;
   logic              delay_clamped;
   logic              out_valid;
   logic signed [BW-1:0] delay_sum_data_out;
   logic              sat_flag;

   delay_sum_beamformer #(.BIT_WIDTH(BW), .NUM_MICS(NM), .MAX_DELAY(MD), .SUM_SHIFT(SS)) dut (
      .clk(clk), .rst(rst), .pcm_valid_in(pcm_valid_in), .pcm_data_in(pcm_data_in),
      .steer_req(steer_req), .steer_busy(steer_busy), .delay_addr(delay_addr),
      .delay_rd_data(delay_rd_data), .delay_clamped(delay_clamped), .out_valid(out_valid),
      .delay_sum_data_out(delay_sum_data_out), .sat_flag(sat_flag));

   always #5 clk = ~clk;

   logic [7:0] rom [32];
   always @(posedge clk) delay_rd_data <= rom[delay_addr];

   int hist [0:2047][0:NM-1];
   int n_in;
   int model_dly [NM];
   int exp_d[$], exp_s[$], got_d[$], got_s[$];
   int checks = 0;
   int errors = 0;

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         got_d.push_back(int'(delay_sum_data_out));
         got_s.push_back(int'(sat_flag));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [NM*BW-1:0] const_vec(input int val);
      logic [NM*BW-1:0] v;
      for (int m = 0; m < NM; m++) v[m*BW +: BW] = BW'(val);
      return v;
   endfunction

   function automatic logic [NM*BW-1:0] rand_vec();
      logic [NM*BW-1:0] v;
      for (int m = 0; m < NM; m++) v[m*BW +: BW] = BW'($urandom_range(0, 255));
      return v;
   endfunction

   // Reference: beam = sum of each mic's sample from model_dly[m] valid samples ago.
   task automatic model_push(input int n);
      int sum = 0;
      int sc, v, s;
      for (int m = 0; m < NM; m++)
         if (n - model_dly[m] >= 0) sum += hist[n - model_dly[m]][m];
      sc = sum >>> SS;
`ifdef OUT_SAT_EN
      if (sc > OMAX)      begin v = OMAX; s = 1; end
      else if (sc < OMIN) begin v = OMIN; s = 1; end
      else                begin v = sc;   s = 0; end
`else
      v = sc & ((1 << BW) - 1);
      if (v > OMAX) v -= (1 << BW);
      s = 0;
`endif
      exp_d.push_back(v);
      exp_s.push_back(s);
   endtask

   task automatic send(input logic v, input logic [NM*BW-1:0] d, input logic req);
      pcm_valid_in = v;
      pcm_data_in  = d;
      steer_req    = req;
      @(posedge clk); #1;
      if (v) begin
         for (int m = 0; m < NM; m++) hist[n_in][m] = int'($signed(d[m*BW +: BW]));
         model_push(n_in);
         n_in++;
      end
      pcm_valid_in = 1'b0;
      steer_req    = 1'b0;
   endtask

   task automatic do_reset();
      pcm_valid_in = 1'b0;
      steer_req    = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_in = 0;
      for (int m = 0; m < NM; m++) model_dly[m] = 0;
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
   endtask

   task automatic apply_rom_to_model();
      for (int m = 0; m < NM; m++) model_dly[m] = (rom[m] >= MD) ? MD - 1 : int'(rom[m]);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 6;
      if (out_valid !== 1'b0)          begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
      if (delay_sum_data_out !== '0)   begin errors++; $display("FAIL rst_data got %0d want 0", delay_sum_data_out); end
      if (sat_flag !== 1'b0)           begin errors++; $display("FAIL rst_sat got %0b want 0", sat_flag); end
      if (steer_busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %0b want 0", steer_busy); end
      if (delay_addr !== '0)           begin errors++; $display("FAIL rst_addr got %0d want 0", delay_addr); end
      if (delay_clamped !== 1'b0)      begin errors++; $display("FAIL rst_clamped got %0b want 0", delay_clamped); end
   endtask

   task automatic test_defaults();
      send(1'b1, const_vec(16), 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL lat1_valid got %0b want 0", out_valid); end
      send(1'b0, '0, 1'b0);
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL lat2_valid got %0b want 1", out_valid); end
      if (delay_sum_data_out !== 8'sd25) begin errors++; $display("FAIL all16_data got %0d want 25", delay_sum_data_out); end
      send(1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_width got %0b want 0", out_valid); end
      for (int i = 0; i < 40; i++) send(1'(i < 20 ? 1 : $urandom_range(0, 1)), rand_vec(), 1'b0);
      repeat (3) send(1'b0, '0, 1'b0);
      checks++;
      if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL default_count got %0d want %0d", got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
            errors++; $display("FAIL default[%0d] got %0d/%0d want %0d/%0d", i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
         end
      end
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
   endtask

   task automatic test_steer_impulse();
      int cyc = 0;
      logic [NM*BW-1:0] imp;
      for (int m = 0; m < 32; m++) rom[m] = 8'd0;
      rom[3] = 8'd5;
      send(1'b0, '0, 1'b1);
      while (steer_busy && cyc < 100) begin cyc++; send(1'b0, '0, 1'b0); end
      checks += 2;
      if (cyc != 27) begin errors++; $display("FAIL steer_busy_len got %0d want 27", cyc); end
      if (delay_addr !== '0) begin errors++; $display("FAIL idle_addr got %0d want 0", delay_addr); end
      apply_rom_to_model();
      repeat (5) send(1'b1, '0, 1'b0);
      repeat (3) send(1'b0, '0, 1'b0);
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
      imp = '0;
      imp[3*BW +: BW] = 8'd100;
      send(1'b1, imp, 1'b0);
      repeat (8) send(1'b1, '0, 1'b0);
      repeat (3) send(1'b0, '0, 1'b0);
      checks++;
      if (got_d.size() != 9) begin errors++; $display("FAIL impulse_count got %0d want 9", got_d.size()); end
      for (int i = 0; i < 9 && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== ((i == 5) ? 6 : 0)) begin
            errors++; $display("FAIL impulse[%0d] got %0d want %0d", i, got_d[i], (i == 5) ? 6 : 0);
         end
      end
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
   endtask

   task automatic test_clamp();
      int cyc = 0;
      for (int m = 0; m < 32; m++) rom[m] = 8'($urandom_range(0, MD - 1));
      rom[7]  = 8'd40;
      rom[12] = 8'd255;
      send(1'b0, '0, 1'b1);
      while (steer_busy && cyc < 100) begin cyc++; send(1'b0, '0, 1'(cyc == 10)); end
      checks += 2;
      if (cyc != 27) begin errors++; $display("FAIL clamp_busy_len got %0d want 27", cyc); end
      if (delay_clamped !== 1'b1) begin errors++; $display("FAIL clamped_flag got %0b want 1", delay_clamped); end
      apply_rom_to_model();
      for (int i = 0; i < 60; i++) send(1'($urandom_range(0, 3) != 0), rand_vec(), 1'b0);
      repeat (3) send(1'b0, '0, 1'b0);
      checks++;
      if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL clamp_count got %0d want %0d", got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
            errors++; $display("FAIL clamp[%0d] got %0d/%0d want %0d/%0d", i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
         end
      end
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
   endtask

   task automatic test_saturation();
      int want_hi, want_lo, want_s;
`ifdef OUT_SAT_EN
      want_hi = 127; want_lo = -128; want_s = 1;
`else
      want_hi = -58; want_lo = 56; want_s = 0;
`endif
      repeat (32) send(1'b1, const_vec(127), 1'b0);
      repeat (3) send(1'b0, '0, 1'b0);
      checks += 2;
      if (got_d.size() == 0 || got_d[got_d.size()-1] !== want_hi) begin
         errors++; $display("FAIL sat_hi_data got %0d want %0d", (got_d.size() == 0) ? 0 : got_d[got_d.size()-1], want_hi);
      end
      if (got_s.size() == 0 || got_s[got_s.size()-1] !== want_s) begin
         errors++; $display("FAIL sat_hi_flag got %0d want %0d", (got_s.size() == 0) ? 0 : got_s[got_s.size()-1], want_s);
      end
      repeat (32) send(1'b1, const_vec(-128), 1'b0);
      repeat (3) send(1'b0, '0, 1'b0);
      checks += 2;
      if (got_d[got_d.size()-1] !== want_lo) begin errors++; $display("FAIL sat_lo_data got %0d want %0d", got_d[got_d.size()-1], want_lo); end
      if (got_s[got_s.size()-1] !== want_s)  begin errors++; $display("FAIL sat_lo_flag got %0d want %0d", got_s[got_s.size()-1], want_s); end
      checks++;
      if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL sat_count got %0d want %0d", got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
            errors++; $display("FAIL sat[%0d] got %0d/%0d want %0d/%0d", i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
         end
      end
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
   endtask

   task automatic test_commit_overlap();
      for (int m = 0; m < 32; m++) rom[m] = 8'($urandom_range(0, MD - 1));
      send(1'b1, rand_vec(), 1'b1);
      for (int k = 1; k < 45; k++) begin
         send(1'b1, rand_vec(), 1'b0);
         if (k == 26) begin
            checks++;
            if (steer_busy !== 1'b1) begin errors++; $display("FAIL commit_busy_hi got %0b want 1", steer_busy); end
         end
         if (k == 27) begin
            checks++;
            if (steer_busy !== 1'b0) begin errors++; $display("FAIL commit_busy_lo got %0b want 0", steer_busy); end
            apply_rom_to_model();
         end
      end
      repeat (3) send(1'b0, '0, 1'b0);
      checks++;
      if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL commit_count got %0d want %0d", got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
            errors++; $display("FAIL commit[%0d] got %0d/%0d want %0d/%0d", i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
         end
      end
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
   endtask

   task automatic test_reset_mid_load();
      for (int m = 0; m < 32; m++) rom[m] = 8'd9;
      send(1'b0, '0, 1'b1);
      repeat (10) send(1'b1, rand_vec(), 1'b0);
      rst = 1'b1;
      #1;
      checks += 5;
      if (steer_busy !== 1'b0)        begin errors++; $display("FAIL midrst_busy got %0b want 0", steer_busy); end
      if (delay_addr !== '0)          begin errors++; $display("FAIL midrst_addr got %0d want 0", delay_addr); end
      if (out_valid !== 1'b0)         begin errors++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
      if (delay_sum_data_out !== '0)  begin errors++; $display("FAIL midrst_data got %0d want 0", delay_sum_data_out); end
      if (delay_clamped !== 1'b0)     begin errors++; $display("FAIL midrst_clamped got %0b want 0", delay_clamped); end
      do_reset();
      for (int i = 0; i < 40; i++) send(1'b1, rand_vec(), 1'b0);
      repeat (3) send(1'b0, '0, 1'b0);
      checks++;
      if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL postrst_count got %0d want %0d", got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
            errors++; $display("FAIL postrst[%0d] got %0d/%0d want %0d/%0d", i, got_d[i], got_s[i], exp_d[i], exp_s[i]);
         end
      end
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
   endtask

   task automatic test_wrap_ramp();
      int cyc = 0;
      int want;
      do_reset();
      for (int m = 0; m < 32; m++) rom[m] = 8'd31;
      send(1'b0, '0, 1'b1);
      while (steer_busy && cyc < 100) begin cyc++; send(1'b0, '0, 1'b0); end
      checks++;
      if (cyc != 27) begin errors++; $display("FAIL wrap_busy_len got %0d want 27", cyc); end
      apply_rom_to_model();
      for (int k = 0; k < 70; k++) send(1'b1, const_vec(k + 1), 1'b0);
      repeat (3) send(1'b0, '0, 1'b0);
      checks++;
      if (got_d.size() != 70) begin errors++; $display("FAIL wrap_count got %0d want 70", got_d.size()); end
      for (int j = 0; j < 70 && j < got_d.size(); j++) begin
         want = (j < 31) ? 0 : ((NM * (j - 30)) >>> SS);
         checks++;
         if (got_d[j] !== want) begin errors++; $display("FAIL wrap[%0d] got %0d want %0d", j, got_d[j], want); end
      end
      exp_d.delete(); exp_s.delete(); got_d.delete(); got_s.delete();
   endtask

   initial begin
      for (int m = 0; m < 32; m++) rom[m] = 8'd0;
      test_reset();
      test_defaults();
      test_steer_impulse();
      test_clamp();
      test_saturation();
      test_commit_overlap();
      test_reset_mid_load();
      test_wrap_ramp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
